// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, RV32 opcodes, fetch FSM encoding and memory defaults.
package cpu_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned IMEM_AW_DEFAULT = 14;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH_FILL = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: execute/decode handshake plus the instruction-memory read port.
interface ifetch_if
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_AW = IMEM_AW_DEFAULT
) ();

    logic               stall;
    logic               redirect;
    logic [XLEN-1:0]    redirectTarget;
    logic               imemEn;
    logic [IMEM_AW-1:0] imemAddr;
    logic [XLEN-1:0]    imemData;
    logic [XLEN-1:0]    inst;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pcPlus4;
    logic               instValid;
    logic               misalign;

    modport master (
        input  stall, redirect, redirectTarget, imemData,
        output imemEn, imemAddr, inst, pc, pcPlus4, instValid, misalign
    );

    modport slave (
        output stall, redirect, redirectTarget, imemData,
        input  imemEn, imemAddr, inst, pc, pcPlus4, instValid, misalign
    );

endinterface

// File: rtl/ifetch_hold_buf.sv
// One-entry skid register: keeps the word returned by memory while decode is stalled.
module ifetch_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         drop,
    input  logic [W-1:0] data,
    output logic [W-1:0] hold_data,
    output logic         hold_valid
);

    // drop outranks capture so a redirect or release always empties the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (drop) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_data  <= data;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC ownership, imem read issue, stall hold and redirect squash.
// Optional redirect alignment check enabled by defining IFETCH_MISALIGN_CHK_EN.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     IMEM_AW  = IMEM_AW_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master fif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            inst_valid_q, inst_valid_d;
    logic [XLEN-1:0] target;
    logic            imem_en_c;
    logic            hold_capture, hold_drop, hold_valid;
    logic [XLEN-1:0] hold_data;

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;

    assign target       = fif.redirectTarget;
    assign fif.misalign = misalign_q;

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
`else
    assign target       = {fif.redirectTarget[XLEN-1:2], 2'b00};
    assign fif.misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_FILL;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    // Redirect beats stall; FILL has no valid output to protect, so it ignores stall
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        imem_en_c    = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            FETCH_FILL, FETCH_RUN: begin
                if (fif.redirect) begin
`ifdef IFETCH_MISALIGN_CHK_EN
                    if (target[1:0] != 2'b00) begin
                        misalign_d   = 1'b1;
                        inst_valid_d = 1'b0;
                        state_d      = FETCH_HALT;
                    end else
`endif
                    begin
                        fetch_pc_d   = target;
                        inst_valid_d = 1'b0;
                        state_d      = FETCH_RUN;
                    end
                end else if (fif.stall && (state_q == FETCH_RUN)) begin
                    imem_en_c = 1'b0;
                end else begin
                    imem_en_c    = 1'b1;
                    pc_d         = fetch_pc_q;
                    fetch_pc_d   = fetch_pc_q + PC_STEP;
                    inst_valid_d = 1'b1;
                    state_d      = FETCH_RUN;
                end
            end
            FETCH_HALT: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH_FILL;
            end
        endcase
    end

    // Capture only the first stall cycle of a valid word; memory output is not held by imem
    assign hold_capture = (state_q == FETCH_RUN) && inst_valid_q && fif.stall
                          && !fif.redirect && !hold_valid;
    assign hold_drop    = fif.redirect || !fif.stall;

    ifetch_hold_buf #(.W(XLEN)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .capture    (hold_capture),
        .drop       (hold_drop),
        .data       (fif.imemData),
        .hold_data  (hold_data),
        .hold_valid (hold_valid)
    );

    assign fif.imemEn    = imem_en_c & ~rst;
    assign fif.imemAddr  = fetch_pc_q[IMEM_AW+1:2];
    assign fif.pc        = pc_q;
    assign fif.pcPlus4   = pc_q + PC_STEP;
    assign fif.instValid = inst_valid_q;
    assign fif.inst      = !inst_valid_q ? INST_NOP
                         : (hold_valid ? hold_data : fif.imemData);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: memory word k holds k, expected fetches queued as stimulus is applied.
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam int unsigned AW = 14;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    ifetch_if #(.IMEM_AW(AW)) fif ();

    ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; output is garbage when not enabled so only the hold buffer can keep a word
    always @(posedge clk)
        fif.imemData <= fif.imemEn ? 32'(fif.imemAddr) : 32'hBAD0_BAD0;

    exp_t        q[$];
    exp_t        last;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seq_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'(a[AW+1:2]);
    endfunction

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = word_at(a);
        q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst                = r;
        fif.stall          = s;
        fif.redirect       = rd;
        fif.redirectTarget = t;
    endtask

    task automatic out_cmp(input string tag);
        chk({tag, "_valid"}, 32'(fif.instValid), 32'd1);
        chk({tag, "_pc"}, fif.pc, last.pc);
        chk({tag, "_inst"}, fif.inst, last.inst);
        chk({tag, "_pcplus4"}, fif.pcPlus4, last.pc + 32'd4);
    endtask

    task automatic out_new(input string tag);
        @(negedge clk);
        checks++;
        assert ((q.size() != 0) === 1'b1) else begin
            errors++;
            $error("FAIL %s_queue observed empty expected entry", tag);
        end
        if (q.size() != 0) last = q.pop_front();
        out_cmp(tag);
    endtask

    task automatic out_same(input string tag);
        @(negedge clk);
        out_cmp(tag);
    endtask

    task automatic out_bubble(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(fif.instValid), 32'd0);
        chk({tag, "_nop"}, fif.inst, INST_NOP);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        fif.stall          = 1'b0;
        fif.redirect       = 1'b0;
        fif.redirectTarget = '0;

        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_imemEn", 32'(fif.imemEn), 32'd0);
        chk("rst_valid", 32'(fif.instValid), 32'd0);
        chk("rst_pc", fif.pc, 32'h0);
        chk("rst_misalign", 32'(fif.misalign), 32'd0);
        chk("rst_inst", fif.inst, INST_NOP);

        // first cycle out of reset
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        out_bubble("fill");
        chk("fill_en", 32'(fif.imemEn), 32'd1);
        chk("fill_addr", 32'(fif.imemAddr), 32'd0);
        push(32'h0); push(32'h4); push(32'h8);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("run0");
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("run4");

        // three stall cycles while pc=8
        cyc(1'b0, 1'b1, 1'b0, 32'h0); out_new("stall_first");
        chk("stall_first_en", 32'(fif.imemEn), 32'd0);
        repeat (2) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0); out_same("stall_hold");
            chk("stall_hold_en", 32'(fif.imemEn), 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_same("stall_release");
        chk("release_en", 32'(fif.imemEn), 32'd1);
        chk("release_addr", 32'(fif.imemAddr), 32'd3);
        push(32'hC); push(32'h10);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("after_release");

        // plain redirect to 0x40
        cyc(1'b0, 1'b0, 1'b1, 32'h40); out_new("redir_cycle");
        chk("redir_cycle_en", 32'(fif.imemEn), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("redir_bubble");
        chk("redir_bubble_addr", 32'(fif.imemAddr), 32'd16);
        push(32'h40); push(32'h44);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("redir_tgt");
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("redir_tgt_next");

        // redirect and stall together
        push(32'h48);
        cyc(1'b0, 1'b1, 1'b1, 32'h80); out_new("redir_stall_cycle");
        chk("redir_stall_en", 32'(fif.imemEn), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("redir_stall_bubble");
        push(32'h80); push(32'h84);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("redir_stall_tgt");
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("redir_stall_next");

        // misaligned redirect target
        push(32'h88);
        cyc(1'b0, 1'b0, 1'b1, 32'h42); out_new("mis_cycle");
`ifdef IFETCH_MISALIGN_CHK_EN
        repeat (3) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("halt");
            chk("halt_en", 32'(fif.imemEn), 32'd0);
            chk("halt_misalign", 32'(fif.misalign), 32'd1);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("halt_rst_en", 32'(fif.imemEn), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("refill");
        chk("refill_misalign", 32'(fif.misalign), 32'd0);
        chk("refill_en", 32'(fif.imemEn), 32'd1);
        push(32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("refill0");
        seq_pc = 32'h4;
`else
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("mis_bubble");
        chk("mis_misalign", 32'(fif.misalign), 32'd0);
        chk("mis_addr", 32'(fif.imemAddr), 32'd16);
        push(32'h40);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("mis_forced");
        seq_pc = 32'h44;
`endif

        // wrap-around at the top of the address space
        push(seq_pc);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC); out_new("wrap_redir");
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("wrap_bubble");
        chk("wrap_addr", 32'(fif.imemAddr), 32'h3FFF);
        push(32'hFFFF_FFFC); push(32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("wrap_top");
        chk("wrap_top_pcplus4", fif.pcPlus4, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("wrap_zero");

        // reset while stalled with a redirect pending
        push(32'h4);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); out_new("pre_rst_stall");
        cyc(1'b1, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        chk("mid_rst_en", 32'(fif.imemEn), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_bubble("post_rst");
        chk("post_rst_pc", fif.pc, 32'h0);
        chk("post_rst_addr", 32'(fif.imemAddr), 32'd0);
        chk("post_rst_en", 32'(fif.imemEn), 32'd1);
        push(32'h0); push(32'h4);
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("post_rst0");
        cyc(1'b0, 1'b0, 1'b0, 32'h0); out_new("post_rst4");

        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
